// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UART transmitter among N_REQ byte streams.
// Optional trailing checksum byte per packet: define UART_ARB_CHECKSUM_EN.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_data_valid,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               busy,
  output logic               pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT      = 3'd2,
    S_ACK       = 3'd3,
    S_NEXT      = 3'd4,
    S_RELEASE   = 3'd5
`ifdef UART_ARB_CHECKSUM_EN
    ,
    S_CSUM      = 3'd6,
    S_CSUM_WAIT = 3'd7
`endif
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] g_idx;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] ptr_after;
  logic             pick_any;
  logic             last_q;
  logic [7:0]       cur_data;
  int               cand;
`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  // Search upward from the pointer; iterating from the far end lets the nearest request win.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req[cand]) begin
        pick_any = 1'b1;
        pick_idx = PTR_W'(cand);
      end
    end
  end

  assign cur_data  = req_data[{g_idx, 3'b000} +: 8];
  assign ptr_after = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ptr_q         <= '0;
      g_idx         <= '0;
      grant         <= '0;
      req_ack       <= '0;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      busy          <= 1'b0;
      pkt_done      <= 1'b0;
      last_q        <= 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      tx_data_valid <= 1'b0;
      req_ack       <= '0;
      pkt_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          // A frame still on the line (e.g. across a reset) blocks new grants.
          if (pick_any && !tx_busy) begin
            grant <= N_REQ'(1) << pick_idx;
            g_idx <= pick_idx;
            busy  <= 1'b1;
`ifdef UART_ARB_CHECKSUM_EN
            csum_q <= 8'h00;
`endif
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_data       <= cur_data;
          tx_data_valid <= 1'b1;
          last_q        <= req_last[g_idx];
`ifdef UART_ARB_CHECKSUM_EN
          csum_q        <= csum_q + cur_data;
`endif
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            req_ack <= grant;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          if (last_q) begin
`ifdef UART_ARB_CHECKSUM_EN
            state <= S_CSUM;
`else
            grant    <= '0;
            ptr_q    <= ptr_after;
            pkt_done <= 1'b1;
            state    <= S_RELEASE;
`endif
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (req[g_idx]) state <= S_LOAD;
        end
`ifdef UART_ARB_CHECKSUM_EN
        S_CSUM: begin
          tx_data       <= csum_q;
          tx_data_valid <= 1'b1;
          state         <= S_CSUM_WAIT;
        end
        S_CSUM_WAIT: begin
          if (tx_done) begin
            grant    <= '0;
            ptr_q    <= ptr_after;
            pkt_done <= 1'b1;
            state    <= S_RELEASE;
          end
        end
`endif
        S_RELEASE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences and randomized packets
// checked against a packet-level round-robin model and a behavioural transmitter.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = 40;  // 10 bits at 4 clk/bit

  typedef logic [7:0] pkt_t [8];
  typedef struct {
    logic [3:0] req_in;
    bit         busy_in;
    logic [3:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_data_valid;
  logic           tx_busy = 1'b0;
  logic           tx_done = 1'b0;
  logic           busy;
  logic           pkt_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] drv_byte [N][$];
  logic       drv_last [N][$];
  int         stall [N];
  int         stall_len [N];
  bit         stall_rand = 1'b0;
  bit         drv_en = 1'b0;
  bit         sb_en = 1'b0;
  bit         tx_force = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] tx_byte = 8'h00;
  int         ack_cnt [N];
  int         exp_ack [N];
  int         pkt_cnt = 0;
  int         exp_pkt = 0;
  vec_t       vecs [7];

  uart_tx_arbiter #(.N_REQ(N), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_busy(tx_busy), .tx_done(tx_done), .busy(busy), .pkt_done(pkt_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #3;
  endtask

  // Transmitter model: accepts a byte on tx_data_valid, busy for one frame, then pulses tx_done.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_cnt > 0) begin
        if (busy) check("tx_data_hold", tx_data, tx_byte);
        check("tx_valid_overlap", tx_data_valid, 1'b0);
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          if (sb_en) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL line_extra: got 0x%0h expected no byte", tx_byte);
            end else begin
              e = exp_q.pop_front();
              check("line_byte", tx_byte, e);
            end
          end
        end
      end else if (tx_data_valid) begin
        tx_byte = tx_data;
        tx_cnt  = FRAME;
      end
      tx_busy = (tx_cnt > 0) || tx_force;
    end
  end

  // Requester drivers: present the queue head, advance on req_ack, optionally stall mid-packet.
  initial begin
    bit was_last;
    forever begin
      @(negedge clk);
      if (drv_en) begin
        for (int i = 0; i < N; i++) begin
          if (req_ack[i] && drv_byte[i].size() > 0) begin
            was_last = drv_last[i][0];
            void'(drv_byte[i].pop_front());
            void'(drv_last[i].pop_front());
            if (!was_last && stall_len[i] > 0)
              stall[i] = stall_rand ? int'($urandom_range(0, stall_len[i])) : stall_len[i];
          end
          if (stall[i] > 0) stall[i]--;
          if (drv_byte[i].size() > 0 && stall[i] == 0) begin
            req[i]            = 1'b1;
            req_data[i*8 +: 8] = drv_byte[i][0];
            req_last[i]       = drv_last[i][0];
          end else begin
            req[i]            = 1'b0;
            req_data[i*8 +: 8] = 8'($urandom);
            req_last[i]       = 1'($urandom);
          end
        end
      end
    end
  end

  // Protocol monitor
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check("grant_onehot0", 32'($onehot0(grant)), 1);
        check("ack_outside_grant", req_ack & ~grant, 0);
        if (req_ack != '0) check("ack_after_done", tx_done, 1'b1);
        for (int i = 0; i < N; i++) ack_cnt[i] += int'(req_ack[i]);
        pkt_cnt += int'(pkt_done);
      end
    end
  end

  task automatic load_pkt(input int r, input pkt_t b, input int len);
    for (int k = 0; k < len; k++) begin
      drv_byte[r].push_back(b[k]);
      drv_last[r].push_back(k == len - 1);
    end
  endtask

  task automatic expect_pkt(input int r, input pkt_t b, input int len);
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0] sum = 8'h00;
`endif
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(b[k]);
`ifdef UART_ARB_CHECKSUM_EN
      sum = sum + b[k];
`endif
    end
`ifdef UART_ARB_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    exp_ack[r] += len;
    exp_pkt++;
  endtask

  task automatic send(input int r, input pkt_t b, input int len);
    load_pkt(r, b, len);
    expect_pkt(r, b, len);
  endtask

  task automatic do_reset(input bit drain);
    int n = 0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_byte[i].delete();
      drv_last[i].delete();
      stall[i] = 0;
    end
    if (!drv_en) begin
      req      = '0;
      req_last = '0;
    end
    tx_force = 1'b0;
    sync();
    check("rst_grant", grant, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_done", pkt_done, 1'b0);
    if (drain) while (tx_cnt != 0 && n < 200) begin sync(); n++; end
    sync();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!tx_data_valid && n < 200) begin sync(); n++; end
    check({name, "_valid_seen"}, 32'(n < 200), 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || tx_cnt != 0) && n < 20000) begin sync(); n++; end
    repeat (3) sync();
    check({name, "_finished"}, 32'(n < 20000), 1);
    for (int i = 0; i < N; i++) check({name, "_ack_count"}, ack_cnt[i], exp_ack[i]);
    check({name, "_pkt_count"}, pkt_cnt, exp_pkt);
    check({name, "_line_left"}, exp_q.size(), 0);
    check({name, "_grant_idle"}, grant, 0);
  endtask

  // Packet-level model: serve whole packets round-robin among requesters that still hold packets.
  task automatic run_random();
    int   mdl_len [N][$];
    logic [7:0] mdl_data [N][$];
    pkt_t b;
    int   p = 0;
    int   len;
    bit   any = 1'b1;
    do_reset(1'b1);
    stall_rand = 1'b1;
    for (int r = 0; r < N; r++) begin
      stall_len[r] = int'($urandom_range(0, 3));
      for (int p2 = 0; p2 < int'($urandom_range(1, 3)); p2++) begin
        len = int'($urandom_range(1, 4));
        for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
        load_pkt(r, b, len);
        mdl_len[r].push_back(len);
        for (int k = 0; k < len; k++) mdl_data[r].push_back(b[k]);
      end
    end
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        int i = (p + k) % N;
        if (mdl_len[i].size() > 0) begin
          len = mdl_len[i].pop_front();
          for (int j = 0; j < len; j++) b[j] = mdl_data[i].pop_front();
          expect_pkt(i, b, len);
          p = (i + 1) % N;
          any = 1'b1;
          break;
        end
      end
    end
    wait_done("random");
    stall_rand = 1'b0;
    for (int r = 0; r < N; r++) stall_len[r] = 0;
  endtask

  initial begin
    pkt_t b;
    int   n;
    int   base;
    for (int i = 0; i < N; i++) begin
      ack_cnt[i] = 0; exp_ack[i] = 0; stall[i] = 0; stall_len[i] = 0;
    end
    vecs[0] = '{4'b0001, 1'b0, 4'b0001, 8'h11};
    vecs[1] = '{4'b0110, 1'b0, 4'b0010, 8'h22};
    vecs[2] = '{4'b1000, 1'b0, 4'b1000, 8'h44};
    vecs[3] = '{4'b1100, 1'b0, 4'b0100, 8'h33};
    vecs[4] = '{4'b0000, 1'b0, 4'b0000, 8'h00};
    vecs[5] = '{4'b1111, 1'b1, 4'b0000, 8'h00};
    vecs[6] = '{4'b1010, 1'b0, 4'b0010, 8'h22};

    // Vector table: first grant from a fresh reset (pointer at 0) and its LOAD one cycle later.
    for (int v = 0; v < 7; v++) begin
      do_reset(1'b1);
      req      = vecs[v].req_in;
      req_data = 32'h44332211;
      tx_force = vecs[v].busy_in;
      sync();
      check("vec_grant", grant, vecs[v].exp_grant);
      check("vec_busy", busy, vecs[v].exp_grant != 0);
      check("vec_valid_early", tx_data_valid, 1'b0);
      sync();
      check("vec_valid", tx_data_valid, vecs[v].exp_grant != 0);
      check("vec_tx_data", tx_data, vecs[v].exp_data);
    end
    req = '0;
    drv_en = 1'b1;
    do_reset(1'b1);
    sb_en = 1'b1;

    // Single packet with latency checks.
    b = '{8'hA5, 8'h3C, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(0, b, 3);
    sync();
    check("lat_grant", grant, 4'b0001);
    check("lat_valid_early", tx_data_valid, 1'b0);
    sync();
    check("lat_valid", tx_data_valid, 1'b1);
    check("lat_data", tx_data, 8'hA5);
    wait_done("single");

    // Round robin: all four, then 0 and 2 with the pointer wrapped back to 0.
    do_reset(1'b1);
    for (int i = 0; i < N; i++) begin
      b[0] = 8'hA0 + 8'(i);
      send(i, b, 1);
    end
    wait_done("rr4");
    b[0] = 8'hB0;
    send(0, b, 1);
    b[0] = 8'hB2;
    send(2, b, 1);
    wait_done("rr2");

    // Atomicity: requester 0 arrives mid-packet of requester 1.
    do_reset(1'b1);
    base = ack_cnt[1];
    b = '{8'h81, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1, b, 2);
    wait_valid("atomic");
    b[0] = 8'h91;
    send(0, b, 1);
    n = 0;
    while (!grant[0] && n < 2000) begin sync(); n++; end
    check("atomic_grant0_seen", 32'(n < 2000), 1);
    check("atomic_r1_done_first", ack_cnt[1] - base, 2);
    wait_done("atomic");

    // Stall: requester 2 drops req for 20 clk after its first, non-last byte.
    do_reset(1'b1);
    stall_len[2] = 20;
    b = '{8'h61, 8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(2, b, 2);
    n = 0;
    while (!req_ack[2] && n < 200) begin sync(); n++; end
    check("stall_first_ack", 32'(n < 200), 1);
    b[0] = 8'h71;
    send(0, b, 1);
    repeat (15) begin
      sync();
      check("stall_grant_held", grant, 4'b0100);
      check("stall_no_valid", tx_data_valid, 1'b0);
    end
    wait_done("stall");
    stall_len[2] = 0;

    // Busy guard: no grant while the transmitter reports busy.
    do_reset(1'b1);
    tx_force = 1'b1;
    b[0] = 8'h55;
    send(0, b, 1);
    repeat (10) begin
      sync();
      check("busy_guard_no_grant", grant, 0);
    end
    tx_force = 1'b0;
    wait_done("busy_guard");

    // Reset during WAIT, then the orphaned tx_done lands in IDLE.
    do_reset(1'b1);
    b = '{8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_pkt(0, b, 2);
    sb_en = 1'b0;
    wait_valid("midrst");
    repeat (3) sync();
    do_reset(1'b0);
    n = 0;
    while (tx_cnt != 0 && n < 200) begin sync(); n++; end
    repeat (3) sync();
    check("stray_done_seen", 32'(n < 200), 1);
    check("stray_no_ack", ack_cnt[0], exp_ack[0]);
    check("stray_no_pkt", pkt_cnt, exp_pkt);
    check("stray_grant", grant, 0);
    check("stray_busy", busy, 1'b0);
    sb_en = 1'b1;

`ifdef UART_ARB_CHECKSUM_EN
    // Checksum: 0x10+0x20+0xF0 = 0x120 -> 0x20 follows on the line, no extra ack.
    do_reset(1'b1);
    b = '{8'h10, 8'h20, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_pkt(3, b, 3);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h20);
    exp_ack[3] += 3;
    exp_pkt++;
    wait_done("csum");
`endif

    run_random();
    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
